// File: rtl/cond_unit_pkg.sv
// Shared encodings for the conditional-execution unit: ARM condition codes,
// NZCV bit positions and the meaning of the two FlagW request bits.
package cond_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW[1] updates N,Z; FlagW[0] updates C,V.
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_unit_cond_check.sv
// Purely combinational evaluation of an ARM condition field against NZCV.
// Code 1111 is unsupported here and always evaluates false.
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n;
  logic z;
  logic c;
  logic v;
  logic ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: NZCV flag register, registered condition result,
// gating of decoder write requests, and executed/skipped instruction counters.
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             IRWrite,
  input  logic             CntClr,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             CondExReg,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SkipCount
);

  logic       cond_ex;
  logic [1:0] flag_write;
  logic       irw_d;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (cond_ex)
  );

  // Condition is evaluated on the pre-write flags, so a failing instruction
  // can never update the flags it was judged against.
  assign flag_write = FlagW & {2{cond_ex}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags <= 4'b0000;
    end else begin
      if (flag_write[FLAGW_NZ]) begin
        Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      end
      if (flag_write[FLAGW_CV]) begin
        Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      CondExReg <= 1'b0;
      irw_d     <= 1'b0;
    end else begin
      CondExReg <= cond_ex;
      irw_d     <= IRWrite;
    end
  end

  assign PCWrite  = (PCS & CondExReg) | NextPC;
  assign RegWrite = RegW & CondExReg;
  assign MemWrite = MemW & CondExReg;

  // irw_d marks the decode cycle: Cond comes from the freshly loaded IR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ExecCount <= '0;
      SkipCount <= '0;
    end else if (CntClr) begin
      ExecCount <= '0;
      SkipCount <= '0;
    end else if (irw_d) begin
      if (cond_ex) begin
        ExecCount <= ExecCount + CNT_W'(1);
      end else begin
        SkipCount <= SkipCount + CNT_W'(1);
      end
    end
  end

endmodule
